// File: rtl/aes0_sched.sv
`default_nettype none
// ============================================================================
// aes0_sched : round-robin scheduler sharing one AES-192 engine among NUM_REQ
//              requesters. Optional job watchdog: AES0_SCHED_TIMEOUT_EN.
// Revision   : 1.0
// ============================================================================
module aes0_sched #(
  parameter int  NUM_REQ        = 4,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   debug_mode_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [2*NUM_REQ-1:0]   req_key_sel_i,
  input  logic [128*NUM_REQ-1:0] req_p_c_i,
  input  logic [128*NUM_REQ-1:0] req_state_i,
  output logic                   aes_start_o,
  output logic [1:0]             aes_key_sel_o,
  output logic [127:0]           aes_p_c_o,
  output logic [127:0]           aes_state_o,
  input  logic                   aes_valid_i,
  input  logic [127:0]           aes_ct_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [ID_W-1:0]        resp_id_o,
  output logic [127:0]           resp_ct_o,
  output logic                   resp_err_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          fsm_q, fsm_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [1:0]      key_sel_q, key_sel_d;
  logic [127:0]    p_c_q, p_c_d;
  logic [127:0]    blk_state_q, blk_state_d;
  logic [127:0]    resp_ct_q, resp_ct_d;
  logic            start_q, start_d;
  logic            resp_valid_q, resp_valid_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   cand;
  logic            timeout;

`ifdef AES0_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_err_q, resp_err_d;

  // Counter holds RUN-cycle index minus one, so the limit hits on RUN cycle TIMEOUT_CYCLES.
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign resp_err_o = resp_err_q;
`else
  assign timeout    = 1'b0;
  assign resp_err_o = 1'b0;
`endif

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grant_vld && req_valid_i[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
    grant_vld = grant_vld & (fsm_q == ST_IDLE) & ~debug_mode_i & ~rst_i;
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_vld) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    fsm_d        = fsm_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    key_sel_d    = key_sel_q;
    p_c_d        = p_c_q;
    blk_state_d  = blk_state_q;
    resp_ct_d    = resp_ct_q;
    start_d      = start_q;
    resp_valid_d = resp_valid_q;
`ifdef AES0_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = resp_err_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (grant_vld) begin
          fsm_d       = ST_RUN;
          start_d     = 1'b1;
          id_d        = grant_idx;
          key_sel_d   = req_key_sel_i[2*grant_idx +: 2];
          p_c_d       = req_p_c_i[128*grant_idx +: 128];
          blk_state_d = req_state_i[128*grant_idx +: 128];
          ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
`ifdef AES0_SCHED_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_RUN: begin
        // A result arriving on the limit cycle takes precedence over the watchdog.
        if (aes_valid_i || timeout) begin
          fsm_d        = ST_RESP;
          start_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_ct_d    = aes_valid_i ? aes_ct_i : '0;
`ifdef AES0_SCHED_TIMEOUT_EN
          resp_err_d   = ~aes_valid_i;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          fsm_d        = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q        <= ST_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      key_sel_q    <= '0;
      p_c_q        <= '0;
      blk_state_q  <= '0;
      resp_ct_q    <= '0;
      start_q      <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef AES0_SCHED_TIMEOUT_EN
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      key_sel_q    <= key_sel_d;
      p_c_q        <= p_c_d;
      blk_state_q  <= blk_state_d;
      resp_ct_q    <= resp_ct_d;
      start_q      <= start_d;
      resp_valid_q <= resp_valid_d;
`ifdef AES0_SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign aes_start_o   = start_q;
  assign aes_key_sel_o = key_sel_q;
  assign aes_p_c_o     = p_c_q;
  assign aes_state_o   = blk_state_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_id_o     = id_q;
  assign resp_ct_o     = resp_ct_q;
  assign busy_o        = (fsm_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes0_sched.sv
`default_nettype none
// ============================================================================
// tb_aes0_sched : directed self-checking bench for aes0_sched with a simple
//                 engine model (result = p_c ^ state ^ key_sel).
// Revision      : 1.0
// ============================================================================
module tb_aes0_sched;

  logic         clk = 1'b0;
  logic         rst, debug_mode;
  logic [3:0]   req_valid, req_ready;
  logic [7:0]   req_key_sel;
  logic [511:0] req_p_c, req_state;
  logic         aes_start, aes_valid;
  logic [1:0]   aes_key_sel;
  logic [127:0] aes_p_c, aes_state, aes_ct;
  logic         resp_valid, resp_ready, resp_err, busy;
  logic [1:0]   resp_id;
  logic [127:0] resp_ct;

  int checks = 0;
  int failures = 0;
  int eng_lat = 0;
  int eng_cnt = 0;

  localparam logic [127:0] P2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] S0   = 128'h55555555555555555555555555555555;
  localparam logic [127:0] CT2  = 128'hffeeddccbbaa99887766554433221101;

  aes0_sched #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .debug_mode_i(debug_mode),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_key_sel_i(req_key_sel), .req_p_c_i(req_p_c), .req_state_i(req_state),
    .aes_start_o(aes_start), .aes_key_sel_o(aes_key_sel),
    .aes_p_c_o(aes_p_c), .aes_state_o(aes_state),
    .aes_valid_i(aes_valid), .aes_ct_i(aes_ct),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_id_o(resp_id), .resp_ct_o(resp_ct), .resp_err_o(resp_err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Engine model: valid for one cycle after eng_lat cycles of start (0 = never).
  always @(negedge clk) begin
    if (aes_start && !rst) begin
      eng_cnt = eng_cnt + 1;
      if (eng_lat != 0 && eng_cnt == eng_lat) begin
        aes_valid = 1'b1;
        aes_ct    = aes_p_c ^ aes_state ^ {126'b0, aes_key_sel};
      end else begin
        aes_valid = 1'b0;
      end
    end else begin
      eng_cnt   = 0;
      aes_valid = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0; debug_mode = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output logic [3:0] vec);
    vec = '0;
    #1;
    for (int n = 0; n < 60; n++) begin
      if (req_ready != 4'b0) begin
        vec = req_ready;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic wait_resp(output int n);
    n = -1;
    for (int k = 0; k < 80; k++) begin
      if (resp_valid) begin
        n = k;
        return;
      end
      tick();
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111;
    tick(); tick();
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if ({aes_start, resp_valid, resp_err, busy} !== 4'b0) begin failures++; $display("FAIL reset_flags: got %b want 0000", {aes_start, resp_valid, resp_err, busy}); end
    checks++; if ({aes_p_c, aes_state, aes_key_sel, resp_ct, resp_id} !== '0) begin failures++; $display("FAIL reset_regs: nonzero holding/resp regs got p_c=%h ct=%h id=%0d", aes_p_c, resp_ct, resp_id); end
    req_valid = '0; rst = 1'b0;
    tick();
    checks++; if ({busy, req_ready} !== 5'b0) begin failures++; $display("FAIL reset_idle: got busy=%b ready=%b want 0 0000", busy, req_ready); end
  endtask

  task automatic test_single_job();
    logic [3:0] v;
    int n;
    do_reset();
    eng_lat = 12;
    tick();
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if ({aes_start, busy} !== 2'b11) begin failures++; $display("FAIL single_start: got start/busy=%b want 11", {aes_start, busy}); end
    checks++; if (aes_key_sel !== 2'd1) begin failures++; $display("FAIL single_key: got %0d want 1", aes_key_sel); end
    checks++; if (aes_p_c !== P2) begin failures++; $display("FAIL single_p_c: got %h want %h", aes_p_c, P2); end
    wait_resp(n);
    checks++; if (n !== 12) begin failures++; $display("FAIL single_latency: got %0d want 12", n); end
    checks++; if (resp_id !== 2'd2) begin failures++; $display("FAIL single_id: got %0d want 2", resp_id); end
    checks++; if (resp_ct !== CT2) begin failures++; $display("FAIL single_ct: got %h want %h", resp_ct, CT2); end
    checks++; if ({resp_err, aes_start} !== 2'b00) begin failures++; $display("FAIL single_err_start: got %b want 00", {resp_err, aes_start}); end
    ack();
    checks++; if ({busy, resp_valid} !== 2'b00) begin failures++; $display("FAIL single_done: got busy/valid=%b want 00", {busy, resp_valid}); end
    v = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] v;
    logic [3:0] exp_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_b [3] = '{4'b0010, 4'b1000, 4'b0010};
    do_reset();
    eng_lat = 2; resp_ready = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(v);
      checks++; if (v !== exp_a[i]) begin failures++; $display("FAIL rr_all_%0d: got %b want %b", i, v, exp_a[i]); end
    end
    do_reset();
    resp_ready = 1'b1; req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      wait_grant(v);
      checks++; if (v !== exp_b[i]) begin failures++; $display("FAIL rr_odd_%0d: got %b want %b", i, v, exp_b[i]); end
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    logic [3:0] v;
    int n;
    do_reset();
    eng_lat = 3; req_valid = 4'b0100;
    wait_grant(v);
    req_valid = '0;
    wait_resp(n);
    checks++; if (n < 0 || resp_ct !== CT2) begin failures++; $display("FAIL bp_first_ct: got n=%0d ct=%h want %h", n, resp_ct, CT2); end
    req_valid = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({resp_valid, aes_start, req_ready} !== 6'b100000 || resp_ct !== CT2 || resp_id !== 2'd2) begin
        failures++;
        $display("FAIL bp_hold_%0d: got valid=%b start=%b ready=%b id=%0d ct=%h want 1 0 0000 2 %h", i, resp_valid, aes_start, req_ready, resp_id, resp_ct, CT2);
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    wait_grant(v);
    req_valid = '0;
    checks++; if (v !== 4'b1000) begin failures++; $display("FAIL bp_next_grant: got %b want 1000", v); end
    wait_resp(n);
    ack();
  endtask

  task automatic test_debug();
    logic [3:0] v;
    int n;
    do_reset();
    eng_lat = 5; req_valid = 4'b0001;
    wait_grant(v);
    checks++; if (v !== 4'b0001) begin failures++; $display("FAIL dbg_grant0: got %b want 0001", v); end
    debug_mode = 1'b1; req_valid = 4'b1111;
    wait_resp(n);
    checks++; if (n < 0 || resp_id !== 2'd0) begin failures++; $display("FAIL dbg_complete: got n=%0d id=%0d want response id 0", n, resp_id); end
    ack();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({busy, req_ready} !== 5'b0) begin failures++; $display("FAIL dbg_blocked_%0d: got busy=%b ready=%b want 0 0000", i, busy, req_ready); end
      tick();
    end
    debug_mode = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL dbg_release: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (aes_start !== 1'b1) begin failures++; $display("FAIL dbg_start: got %b want 1", aes_start); end
    wait_resp(n);
    ack();
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] v;
    int n;
    do_reset();
    eng_lat = 20; req_valid = 4'b0100;
    wait_grant(v);
    req_valid = '0;
    tick(); tick(); tick(); tick();
    checks++; if (aes_start !== 1'b1) begin failures++; $display("FAIL rst_run5_start: got %b want 1", aes_start); end
    rst = 1'b1; req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rst_ready_low: got %b want 0000", req_ready); end
    tick();
    checks++; if ({aes_start, busy, resp_valid} !== 3'b000) begin failures++; $display("FAIL rst_discard: got start/busy/valid=%b want 000", {aes_start, busy, resp_valid}); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rst_next_grant: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    wait_resp(n);
    checks++; if (n < 0 || resp_id !== 2'd1) begin failures++; $display("FAIL rst_next_resp: got n=%0d id=%0d want id 1", n, resp_id); end
    ack();
  endtask

`ifdef AES0_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] v;
    int n;
    do_reset();
    eng_lat = 0; req_valid = 4'b0001;
    wait_grant(v);
    req_valid = '0;
    wait_resp(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL to_latency: got %0d want 16", n); end
    checks++; if ({resp_err, resp_ct} !== {1'b1, 128'h0}) begin failures++; $display("FAIL to_err: got err=%b ct=%h want 1 0", resp_err, resp_ct); end
    ack();
    eng_lat = 16; req_valid = 4'b0001;
    wait_grant(v);
    req_valid = '0;
    wait_resp(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL to_edge_latency: got %0d want 16", n); end
    checks++; if ({resp_err, resp_ct} !== {1'b0, S0}) begin failures++; $display("FAIL to_edge_ok: got err=%b ct=%h want 0 %h", resp_err, resp_ct, S0); end
    ack();
  endtask
`endif

  initial begin
    rst = 1'b1; debug_mode = 1'b0; req_valid = '0; resp_ready = 1'b0;
    aes_valid = 1'b0; aes_ct = '0;
    req_key_sel = 8'b11_01_10_00;
    req_p_c     = {128'h3, P2, 128'h1, 128'h0};
    req_state   = {128'h33, {128{1'b1}}, 128'h11, S0};
    test_reset();
    test_single_job();
    test_round_robin();
    test_backpressure();
    test_debug();
    test_reset_mid_run();
`ifdef AES0_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
